core_itcm_arb: RTL and testbench

- Single-port arbiter and sequencer in front of the core's ITCM SRAM.
- Shares the ITCM between two requesters:
  - the instruction-fetch path (inst port, read-only);
  - the load/store path (data port, read/write).
- Per-port req/gnt/rvalid handshake; 1-cycle SRAM read latency.
- Holds a 1-deep response-ownership pipeline, a starvation counter and an address-range error check.

---
 rtl/core_itcm_arb_pkg.sv | 22 ++
 rtl/core_itcm_arb_if.sv | 51 +++++
 rtl/core_itcm_prio.sv | 44 ++++
 rtl/core_itcm_arb.sv | 113 +++++++++++
 tb/tb_core_itcm_arb.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_itcm_arb_pkg.sv
// Shared types and constants for the ITCM arbiter slice.
package core_itcm_arb_pkg;

    localparam int unsigned ITCM_AW_DEFAULT = 14;
    localparam int unsigned BE_W            = 4;
    localparam logic [BE_W-1:0] BE_FULL     = 4'hF;

    // Which port owns the response presented in the cycle after a grant.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_INST = 2'd1,
        OWNER_DATA = 2'd2
    } resp_owner_e;

    // Response-ownership pipeline stage captured at grant.
    typedef struct packed {
        resp_owner_e owner;
        logic        err;
        logic        rd;
    } resp_t;

endpackage

// File: rtl/core_itcm_arb_if.sv
// Fetch, load/store and SRAM signal bundle seen by the ITCM arbiter.
interface core_itcm_arb_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ITCM_AW = 14
);
    logic                                inst_req_i;
    logic [ADDR_W-1:0]                   inst_addr_i;
    logic                                inst_gnt_o;
    logic                                inst_rvalid_o;
    logic [DATA_W-1:0]                   inst_rdata_o;
    logic                                inst_err_o;
    logic                                inst_flush_i;

    logic                                data_req_i;
    logic                                data_we_i;
    logic [core_itcm_arb_pkg::BE_W-1:0]  data_be_i;
    logic [ADDR_W-1:0]                   data_addr_i;
    logic [DATA_W-1:0]                   data_wdata_i;
    logic                                data_gnt_o;
    logic                                data_rvalid_o;
    logic [DATA_W-1:0]                   data_rdata_o;
    logic                                data_err_o;

    logic                                mem_en_o;
    logic                                mem_we_o;
    logic [core_itcm_arb_pkg::BE_W-1:0]  mem_be_o;
    logic [ITCM_AW-1:0]                  mem_addr_o;
    logic [DATA_W-1:0]                   mem_wdata_o;
    logic [DATA_W-1:0]                   mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  inst_req_i, inst_addr_i, inst_flush_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_rdata_i,
        output inst_gnt_o, inst_rvalid_o, inst_rdata_o, inst_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    // Requesters plus SRAM side.
    modport master (
        output inst_req_i, inst_addr_i, inst_flush_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_rdata_i,
        input  inst_gnt_o, inst_rvalid_o, inst_rdata_o, inst_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/core_itcm_prio.sv
// Fixed-priority pick (data first) with a starvation guard for the fetch port.
module core_itcm_prio #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inst_req_i,
    input  logic data_req_i,
    output logic grant_inst,
    output logic grant_data
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved_c;

    assign starved_c = (starve_cnt == CNT_W'(STARVE_MAX));

    // Data wins unless the waiting fetch has been passed over STARVE_MAX times.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!rst_i) begin
            if (data_req_i && !(inst_req_i && starved_c)) begin
                grant_data = 1'b1;
            end else if (inst_req_i) begin
                grant_inst = 1'b1;
            end
        end
    end

    // Count consecutive data grants taken while a fetch is waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (!inst_req_i || grant_inst) begin
            starve_cnt <= '0;
        end else if (grant_data && !starved_c) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_itcm_arb.sv
// Single-port ITCM arbiter: grant muxing onto the SRAM and 1-cycle response routing.
module core_itcm_arb
    import core_itcm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ITCM_AW    = ITCM_AW_DEFAULT,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    core_itcm_arb_if.slave  bus
);

    localparam int unsigned HI_LSB = ITCM_AW + 2;

    logic               grant_inst;
    logic               grant_data;
    logic               inst_in_range_c;
    logic               data_in_range_c;
    logic [ITCM_AW-1:0] inst_word_c;
    logic [ITCM_AW-1:0] data_word_c;

    logic               mem_en_c;
    logic               mem_we_c;
    logic [BE_W-1:0]    mem_be_c;
    logic [ITCM_AW-1:0] mem_addr_c;
    logic [DATA_W-1:0]  mem_wdata_c;

    resp_t              resp_d;
    resp_t              resp_q;

    logic               inst_valid_c;
    logic               data_valid_c;
    logic               unused_addr_bits;

    core_itcm_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inst_req_i (bus.inst_req_i),
        .data_req_i (bus.data_req_i),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // Address decode: anything above the ITCM window is an error.
    assign inst_in_range_c  = (bus.inst_addr_i[ADDR_W-1:HI_LSB] == '0);
    assign data_in_range_c  = (bus.data_addr_i[ADDR_W-1:HI_LSB] == '0);
    assign inst_word_c      = bus.inst_addr_i[HI_LSB-1:2];
    assign data_word_c      = bus.data_addr_i[HI_LSB-1:2];
    assign unused_addr_bits = ^{bus.inst_addr_i[1:0], bus.data_addr_i[1:0]};

    // Steer the granted, in-range request onto the SRAM port.
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_be_c    = '0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (grant_data && data_in_range_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.data_we_i;
            mem_be_c    = bus.data_we_i ? bus.data_be_i : BE_FULL;
            mem_addr_c  = data_word_c;
            mem_wdata_c = bus.data_wdata_i;
        end else if (grant_inst && inst_in_range_c) begin
            mem_en_c    = 1'b1;
            mem_be_c    = BE_FULL;
            mem_addr_c  = inst_word_c;
        end
    end

    // Next response owner; a fetch flushed in its grant cycle never claims the response.
    always_comb begin
        resp_d = '{owner: OWNER_NONE, err: 1'b0, rd: 1'b0};
        if (grant_data) begin
            resp_d = '{owner: OWNER_DATA, err: !data_in_range_c, rd: !bus.data_we_i};
        end else if (grant_inst && !bus.inst_flush_i) begin
            resp_d = '{owner: OWNER_INST, err: !inst_in_range_c, rd: 1'b1};
        end
    end

    // Response-ownership pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q <= '{owner: OWNER_NONE, err: 1'b0, rd: 1'b0};
        end else begin
            resp_q <= resp_d;
        end
    end

    assign inst_valid_c = !rst_i && (resp_q.owner == OWNER_INST) && !bus.inst_flush_i;
    assign data_valid_c = !rst_i && (resp_q.owner == OWNER_DATA);

    assign bus.inst_gnt_o    = grant_inst;
    assign bus.data_gnt_o    = grant_data;
    assign bus.mem_en_o      = mem_en_c;
    assign bus.mem_we_o      = mem_we_c;
    assign bus.mem_be_o      = mem_be_c;
    assign bus.mem_addr_o    = mem_addr_c;
    assign bus.mem_wdata_o   = mem_wdata_c;

    assign bus.inst_rvalid_o = inst_valid_c;
    assign bus.inst_err_o    = inst_valid_c && resp_q.err;
    assign bus.inst_rdata_o  = (inst_valid_c && resp_q.rd && !resp_q.err) ? bus.mem_rdata_i : '0;

    assign bus.data_rvalid_o = data_valid_c;
    assign bus.data_err_o    = data_valid_c && resp_q.err;
    assign bus.data_rdata_o  = (data_valid_c && resp_q.rd && !resp_q.err) ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_core_itcm_arb.sv
// Directed bench for core_itcm_arb with a response scoreboard and a small SRAM model.
module tb_core_itcm_arb;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ITCM_AW    = 14;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    exp_t inst_q[$];
    exp_t data_q[$];
    exp_t ie;
    exp_t de;

    logic [31:0] sram [0:(1<<ITCM_AW)-1];

    always #5 clk = ~clk;

    core_itcm_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ITCM_AW(ITCM_AW)) bus ();

    core_itcm_arb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ITCM_AW    (ITCM_AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: preload during reset, 1-cycle read, byte-enabled write.
    always @(posedge clk) begin
        if (rst_i) begin
            sram[0]       <= 32'hCAFE_0000;
            sram[4]       <= 32'h0000_0013;
            sram[8]       <= 32'hA5A5_0008;
            sram[14'h41]  <= 32'h1122_3344;
            sram[14'h3FFF] <= 32'h0BAD_F00D;
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
                end
            end else begin
                bus.mem_rdata_i <= sram[bus.mem_addr_o];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the head of its port queue; a due entry without rvalid is missing.
    always @(negedge clk) begin
        if (bus.inst_rvalid_o) begin
            if (inst_q.size() != 0 && inst_q[0].due == cyc) begin
                ie = inst_q.pop_front();
                chk("inst_rdata", bus.inst_rdata_o, ie.rdata);
                chk("inst_err", 32'(bus.inst_err_o), 32'(ie.err));
            end else begin
                chk("inst_rvalid_unexpected", 32'(bus.inst_rvalid_o), 32'd0);
            end
        end else if (inst_q.size() != 0 && inst_q[0].due <= cyc) begin
            void'(inst_q.pop_front());
            chk("inst_rvalid_missing", 32'(bus.inst_rvalid_o), 32'd1);
        end

        if (bus.data_rvalid_o) begin
            if (data_q.size() != 0 && data_q[0].due == cyc) begin
                de = data_q.pop_front();
                chk("data_rdata", bus.data_rdata_o, de.rdata);
                chk("data_err", 32'(bus.data_err_o), 32'(de.err));
            end else begin
                chk("data_rvalid_unexpected", 32'(bus.data_rvalid_o), 32'd0);
            end
        end else if (data_q.size() != 0 && data_q[0].due <= cyc) begin
            void'(data_q.pop_front());
            chk("data_rvalid_missing", 32'(bus.data_rvalid_o), 32'd1);
        end
    end

    // One request cycle: drive, check grant/SRAM port mid-cycle, queue the expected response.
    task automatic step(
        input logic ir, input logic [31:0] ia, input logic ifl,
        input logic dr, input logic dwe, input logic [3:0] dbe,
        input logic [31:0] da, input logic [31:0] dwd,
        input logic eig, input logic edg, input logic een, input logic ewe,
        input logic [3:0] ebe, input logic [13:0] ead,
        input logic ersp, input logic [31:0] erd, input logic eerr
    );
        bus.inst_req_i   = ir;
        bus.inst_addr_i  = ia;
        bus.inst_flush_i = ifl;
        bus.data_req_i   = dr;
        bus.data_we_i    = dwe;
        bus.data_be_i    = dbe;
        bus.data_addr_i  = da;
        bus.data_wdata_i = dwd;
        @(negedge clk);
        chk("inst_gnt", 32'(bus.inst_gnt_o), 32'(eig));
        chk("data_gnt", 32'(bus.data_gnt_o), 32'(edg));
        chk("mem_en", 32'(bus.mem_en_o), 32'(een));
        if (een) begin
            chk("mem_we", 32'(bus.mem_we_o), 32'(ewe));
            chk("mem_be", 32'(bus.mem_be_o), 32'(ebe));
            chk("mem_addr", 32'(bus.mem_addr_o), 32'(ead));
            if (ewe) chk("mem_wdata", bus.mem_wdata_o, dwd);
        end
        if (ersp && eig) inst_q.push_back('{rdata: erd, err: eerr, due: cyc + 1});
        if (ersp && edg) data_q.push_back('{rdata: erd, err: eerr, due: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ifl);
        step(1'b0, 32'h0, ifl, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.inst_req_i   = 1'b0;
        bus.inst_addr_i  = '0;
        bus.inst_flush_i = 1'b0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
        @(posedge clk);
        #1;

        // Reset held 3 cycles with both requests high: nothing granted.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 1'b0, 32'h0, 1'b0);
        end
        rst_i = 1'b0;

        // First cycle out of reset: data wins.
        step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0,
             1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h0, 1'b1, 32'hCAFE_0000, 1'b0);
        idle(1'b0);

        // Single fetch at 0x10 -> word 4.
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 14'h4, 1'b1, 32'h0000_0013, 1'b0);

        // Store 0xDEADBEEF, be=0011 at 0x104 -> word 0x41, then read back merged word.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h104, 32'hDEAD_BEEF,
             1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 14'h41, 1'b1, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0,
             1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h41, 1'b1, 32'h1122_BEEF, 1'b0);

        // Starvation: both held, expect D D D D I repeating.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0,
                     1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h8, 1'b1, 32'hA5A5_0008, 1'b0);
            end
            step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 14'h4, 1'b1, 32'h0000_0013, 1'b0);
        end
        idle(1'b0);

        // Range boundaries: last in-range word, then out-of-range data and fetch.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0,
             1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h3FFF, 1'b1, 32'h0BAD_F00D, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0,
             1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 1'b1, 32'h0, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 1'b1, 32'h0, 1'b1);
        idle(1'b0);

        // Flush in the response cycle, then in the grant cycle: no fetch response.
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 14'h4, 1'b0, 32'h0, 1'b0);
        idle(1'b1);
        step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 14'h4, 1'b0, 32'h0, 1'b0);
        idle(1'b0);

        // Flush never touches a data response.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0,
             1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h8, 1'b1, 32'hA5A5_0008, 1'b0);
        idle(1'b1);

        // Reset right after a data grant drops its response.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0,
             1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h8, 1'b0, 32'h0, 1'b0);
        rst_i = 1'b1;
        idle(1'b0);
        rst_i = 1'b0;
        idle(1'b0);
        idle(1'b0);

        chk("inst_q_drained", 32'(inst_q.size()), 32'd0);
        chk("data_q_drained", 32'(data_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
